// File: rtl/enclave_loader.sv
// Word-by-word copy engine that moves an enclave image from a source region to enclave memory.
// Drives the strt_cpy/done_cpy session pair consumed by the security monitor; every output is registered.
module enclave_loader #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              aclk,
    input  logic              nreset,
    input  logic              go,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len_words,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ack,
    output logic              strt_cpy,
    output logic              done_cpy,
    output logic              busy,
    output logic              aborted,
    output logic [LEN_W-1:0]  words_done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(DATA_W / 8);
    localparam logic [LEN_W-1:0]  ONE_WORD = LEN_W'(1);
    localparam logic [LEN_W-1:0]  NO_WORDS = LEN_W'(0);

    // Pointers wrap silently modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] step_ptr(input logic [ADDR_W-1:0] ptr);
        return ptr + STRIDE;
    endfunction

    state_t            state_r, state_nxt_s;
    logic [ADDR_W-1:0] src_ptr_r, src_ptr_nxt_s;
    logic [ADDR_W-1:0] dst_ptr_r, dst_ptr_nxt_s;
    logic [ADDR_W-1:0] rd_addr_r, rd_addr_nxt_s;
    logic [ADDR_W-1:0] wr_addr_r, wr_addr_nxt_s;
    logic [DATA_W-1:0] data_r, data_nxt_s;
    logic [LEN_W-1:0]  len_r, len_nxt_s;
    logic [LEN_W-1:0]  words_done_r, words_done_nxt_s;
    logic              rd_req_r, rd_req_nxt_s;
    logic              wr_req_r, wr_req_nxt_s;
    logic              strt_r, strt_nxt_s;
    logic              done_r, done_nxt_s;
    logic              busy_r, busy_nxt_s;
    logic              aborted_r, aborted_nxt_s;
    logic              armed_r, armed_nxt_s;
    logic              last_word_s;

    assign last_word_s = ((words_done_r + ONE_WORD) == len_r);

    // Next-state and next-output decode; armed_r records that go was seen low in IDLE.
    always_comb begin
        state_nxt_s      = state_r;
        src_ptr_nxt_s    = src_ptr_r;
        dst_ptr_nxt_s    = dst_ptr_r;
        rd_addr_nxt_s    = rd_addr_r;
        wr_addr_nxt_s    = wr_addr_r;
        data_nxt_s       = data_r;
        len_nxt_s        = len_r;
        words_done_nxt_s = words_done_r;
        rd_req_nxt_s     = rd_req_r;
        wr_req_nxt_s     = wr_req_r;
        strt_nxt_s       = strt_r;
        done_nxt_s       = done_r;
        aborted_nxt_s    = aborted_r;
        armed_nxt_s      = armed_r;

        case (state_r)
            ST_IDLE: begin
                if (go && armed_r) begin
                    armed_nxt_s      = 1'b0;
                    len_nxt_s        = len_words;
                    src_ptr_nxt_s    = src_addr;
                    dst_ptr_nxt_s    = dst_addr;
                    words_done_nxt_s = NO_WORDS;
                    aborted_nxt_s    = 1'b0;
                    strt_nxt_s       = 1'b1;
                    if (len_words == NO_WORDS) begin
                        state_nxt_s = ST_DONE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s   = ST_READ;
                        rd_req_nxt_s  = 1'b1;
                        rd_addr_nxt_s = src_addr;
                    end
                end else if (!go) begin
                    armed_nxt_s = 1'b1;
                end else begin
                    armed_nxt_s = armed_r;
                end
            end

            ST_READ: begin
                if (rd_valid) begin
                    rd_req_nxt_s  = 1'b0;
                    src_ptr_nxt_s = step_ptr(src_ptr_r);
                    if (!go) begin
                        // Data arriving with the abort is dropped.
                        state_nxt_s   = ST_IDLE;
                        strt_nxt_s    = 1'b0;
                        aborted_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s   = ST_WRITE;
                        data_nxt_s    = rd_data;
                        wr_req_nxt_s  = 1'b1;
                        wr_addr_nxt_s = dst_ptr_r;
                    end
                end else if (!go) begin
                    state_nxt_s   = ST_DRAIN;
                    strt_nxt_s    = 1'b0;
                    aborted_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end

            ST_WRITE: begin
                if (wr_ack) begin
                    wr_req_nxt_s     = 1'b0;
                    words_done_nxt_s = words_done_r + ONE_WORD;
                    dst_ptr_nxt_s    = step_ptr(dst_ptr_r);
                    if (!go) begin
                        // An abort wins over the final ack: done_cpy is never raised.
                        state_nxt_s   = ST_IDLE;
                        strt_nxt_s    = 1'b0;
                        aborted_nxt_s = 1'b1;
                    end else if (last_word_s) begin
                        state_nxt_s = ST_DONE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s   = ST_READ;
                        rd_req_nxt_s  = 1'b1;
                        rd_addr_nxt_s = src_ptr_r;
                    end
                end else if (!go) begin
                    state_nxt_s   = ST_DRAIN;
                    strt_nxt_s    = 1'b0;
                    aborted_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end

            ST_DONE: begin
                if (!go) begin
                    state_nxt_s = ST_IDLE;
                    strt_nxt_s  = 1'b0;
                    done_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end

            ST_DRAIN: begin
                if (rd_req_r && rd_valid) begin
                    rd_req_nxt_s = 1'b0;
                    state_nxt_s  = ST_IDLE;
                end else if (wr_req_r && wr_ack) begin
                    wr_req_nxt_s     = 1'b0;
                    words_done_nxt_s = words_done_r + ONE_WORD;
                    dst_ptr_nxt_s    = step_ptr(dst_ptr_r);
                    state_nxt_s      = ST_IDLE;
                end else if (!rd_req_r && !wr_req_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end

            default: begin
                state_nxt_s  = ST_IDLE;
                rd_req_nxt_s = 1'b0;
                wr_req_nxt_s = 1'b0;
                strt_nxt_s   = 1'b0;
                done_nxt_s   = 1'b0;
            end
        endcase

        busy_nxt_s = (state_nxt_s == ST_READ) || (state_nxt_s == ST_WRITE) ||
                     (state_nxt_s == ST_DRAIN);
    end

    // FSM state register.
    always_ff @(posedge aclk) begin
        if (!nreset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge aclk) begin
        if (!nreset) begin
            src_ptr_r    <= {ADDR_W{1'b0}};
            dst_ptr_r    <= {ADDR_W{1'b0}};
            rd_addr_r    <= {ADDR_W{1'b0}};
            wr_addr_r    <= {ADDR_W{1'b0}};
            data_r       <= {DATA_W{1'b0}};
            len_r        <= NO_WORDS;
            words_done_r <= NO_WORDS;
            rd_req_r     <= 1'b0;
            wr_req_r     <= 1'b0;
            strt_r       <= 1'b0;
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
            aborted_r    <= 1'b0;
            armed_r      <= 1'b0;
        end else begin
            src_ptr_r    <= src_ptr_nxt_s;
            dst_ptr_r    <= dst_ptr_nxt_s;
            rd_addr_r    <= rd_addr_nxt_s;
            wr_addr_r    <= wr_addr_nxt_s;
            data_r       <= data_nxt_s;
            len_r        <= len_nxt_s;
            words_done_r <= words_done_nxt_s;
            rd_req_r     <= rd_req_nxt_s;
            wr_req_r     <= wr_req_nxt_s;
            strt_r       <= strt_nxt_s;
            done_r       <= done_nxt_s;
            busy_r       <= busy_nxt_s;
            aborted_r    <= aborted_nxt_s;
            armed_r      <= armed_nxt_s;
        end
    end

    assign rd_req     = rd_req_r;
    assign rd_addr    = rd_addr_r;
    assign wr_req     = wr_req_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = data_r;
    assign strt_cpy   = strt_r;
    assign done_cpy   = done_r;
    assign busy       = busy_r;
    assign aborted    = aborted_r;
    assign words_done = words_done_r;

endmodule

// File: tb/tb_enclave_loader.sv
// Bench for enclave_loader: a responsive fabric with configurable latency and a reference
// copy model (expected address/data sequences derived from src, dst and len) per session.
module tb_enclave_loader;

    logic        aclk = 1'b0;
    logic        nreset = 1'b0;
    logic        go = 1'b0;
    logic [31:0] src_addr = 32'd0;
    logic [31:0] dst_addr = 32'd0;
    logic [15:0] len_words = 16'd0;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_valid = 1'b0;
    logic [31:0] rd_data = 32'd0;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ack = 1'b0;
    logic        strt_cpy;
    logic        done_cpy;
    logic        busy;
    logic        aborted;
    logic [15:0] words_done;

    int vectors = 0;
    int miscompares = 0;

    int          rd_delay = 0;
    int          wr_delay = 0;
    bit          spur = 1'b0;
    logic [31:0] seed = 32'd0;

    logic [31:0] rd_log[$];
    logic [31:0] wa_log[$];
    logic [31:0] wd_log[$];
    int          done_cnt = 0;
    int          stab_err = 0;
    logic        prv_rd_pend = 1'b0;
    logic        prv_wr_pend = 1'b0;
    logic [31:0] prv_rd_addr = 32'd0;
    logic [31:0] prv_wr_addr = 32'd0;
    logic [31:0] prv_wr_data = 32'd0;

    always #5 aclk = ~aclk;

    enclave_loader #(.ADDR_W(32), .DATA_W(32), .LEN_W(16)) dut (
        .aclk(aclk), .nreset(nreset), .go(go),
        .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .strt_cpy(strt_cpy), .done_cpy(done_cpy), .busy(busy),
        .aborted(aborted), .words_done(words_done)
    );

    // Source memory contents: a per-session hash of the byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a ^ seed) * 32'h9E3779B1) + 32'h0123_4567;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Fabric: answers a request after a fixed number of waiting cycles, optionally with noise when idle.
    initial begin
        int rd_wait;
        int wr_wait;
        rd_wait = 0;
        wr_wait = 0;
        forever begin
            @(posedge aclk);
            #1;
            if (rd_req) begin
                if (rd_wait >= rd_delay) begin
                    rd_valid = 1'b1;
                    rd_data  = mem_word(rd_addr);
                    rd_wait  = 0;
                end else begin
                    rd_valid = 1'b0;
                    rd_wait++;
                end
            end else begin
                rd_valid = spur ? 1'($urandom_range(0, 1)) : 1'b0;
                rd_data  = $urandom;
                rd_wait  = 0;
            end
            if (wr_req) begin
                if (wr_wait >= wr_delay) begin
                    wr_ack  = 1'b1;
                    wr_wait = 0;
                end else begin
                    wr_ack = 1'b0;
                    wr_wait++;
                end
            end else begin
                wr_ack  = spur ? 1'($urandom_range(0, 1)) : 1'b0;
                wr_wait = 0;
            end
        end
    end

    // Handshake log and request-stability monitor, sampled mid-cycle.
    always @(negedge aclk) begin
        if (nreset) begin
            stab_err <= stab_err
                + ((prv_rd_pend && (!rd_req || rd_addr !== prv_rd_addr)) ? 1 : 0)
                + ((prv_wr_pend && (!wr_req || wr_addr !== prv_wr_addr || wr_data !== prv_wr_data)) ? 1 : 0);
            if (rd_req && rd_valid) rd_log.push_back(rd_addr);
            if (wr_req && wr_ack) begin
                wa_log.push_back(wr_addr);
                wd_log.push_back(wr_data);
            end
            done_cnt <= done_cnt + (done_cpy ? 1 : 0);
        end
        prv_rd_pend <= nreset && rd_req && !rd_valid;
        prv_wr_pend <= nreset && wr_req && !wr_ack;
        prv_rd_addr <= rd_addr;
        prv_wr_addr <= wr_addr;
        prv_wr_data <= wr_data;
    end

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_rd_req"}, 64'(rd_req), 64'd0);
        check_val({tag, "_wr_req"}, 64'(wr_req), 64'd0);
        check_val({tag, "_strt"}, 64'(strt_cpy), 64'd0);
        check_val({tag, "_done"}, 64'(done_cpy), 64'd0);
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_aborted"}, 64'(aborted), 64'd0);
        check_val({tag, "_words"}, 64'(words_done), 64'd0);
        check_val({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
        check_val({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        check_val({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    endtask

    // One host session; abort_k>0 drops go while the abort_k-th write is pending.
    task automatic run_copy(input string tag, input logic [31:0] s, input logic [31:0] d,
                            input int n, input int rdl, input int wdl, input int abort_k, input bit noise);
        int cyc;
        int exp_words;
        int rd_base;
        int wr_base;
        int done_base;
        int stab_base;
        logic [31:0] ea;
        rd_delay  = rdl;
        wr_delay  = wdl;
        spur      = noise;
        seed      = $urandom;
        src_addr  = s;
        dst_addr  = d;
        len_words = 16'(n);
        repeat (2) @(posedge aclk);
        #1;
        rd_base   = rd_log.size();
        wr_base   = wa_log.size();
        done_base = done_cnt;
        stab_base = stab_err;
        go = 1'b1;
        @(posedge aclk);
        #1;
        check_val({tag, "_strt"}, 64'(strt_cpy), 64'd1);
        check_val({tag, "_aborted_clr"}, 64'(aborted), 64'd0);
        if (n == 0) begin
            check_val({tag, "_done0"}, 64'(done_cpy), 64'd1);
            check_val({tag, "_rdreq0"}, 64'(rd_req), 64'd0);
            check_val({tag, "_busy0"}, 64'(busy), 64'd0);
        end else begin
            check_val({tag, "_rdreq1"}, 64'(rd_req), 64'd1);
            check_val({tag, "_rdaddr1"}, 64'(rd_addr), 64'(s));
            check_val({tag, "_busy1"}, 64'(busy), 64'd1);
        end
        if (abort_k == 0) begin
            cyc = 0;
            while (!done_cpy && cyc < 4000) begin
                @(posedge aclk);
                #1;
                cyc++;
            end
            check_val({tag, "_done"}, 64'(done_cpy), 64'd1);
            if (rdl == 0 && wdl == 0) check_val({tag, "_latency"}, 64'(cyc), 64'(2 * n));
            check_val({tag, "_words"}, 64'(words_done), 64'(n));
            check_val({tag, "_aborted"}, 64'(aborted), 64'd0);
            check_val({tag, "_busy_end"}, 64'(busy), 64'd0);
            repeat (2) begin
                @(posedge aclk);
                #1;
                check_val({tag, "_done_hold"}, 64'(done_cpy), 64'd1);
                check_val({tag, "_strt_hold"}, 64'(strt_cpy), 64'd1);
                check_val({tag, "_reqs_quiet"}, 64'({rd_req, wr_req}), 64'd0);
            end
            go = 1'b0;
            @(posedge aclk);
            #1;
            check_val({tag, "_drop"}, 64'({strt_cpy, done_cpy}), 64'd0);
            exp_words = n;
        end else begin
            cyc = 0;
            while (!(wr_req && wa_log.size() == wr_base + abort_k - 1) && cyc < 4000) begin
                @(posedge aclk);
                #1;
                cyc++;
            end
            check_val({tag, "_abort_point"}, 64'(wr_req), 64'd1);
            go = 1'b0;
            @(posedge aclk);
            #1;
            check_val({tag, "_strt_off"}, 64'(strt_cpy), 64'd0);
            check_val({tag, "_aborted_set"}, 64'(aborted), 64'd1);
            if (wdl > 0) check_val({tag, "_wr_held"}, 64'(wr_req), 64'd1);
            cyc = 0;
            while (busy && cyc < 4000) begin
                @(posedge aclk);
                #1;
                cyc++;
            end
            check_val({tag, "_drained"}, 64'(busy), 64'd0);
            repeat (4) @(posedge aclk);
            #1;
            check_val({tag, "_words"}, 64'(words_done), 64'(abort_k));
            check_val({tag, "_aborted"}, 64'(aborted), 64'd1);
            check_val({tag, "_never_done"}, 64'(done_cnt - done_base), 64'd0);
            check_val({tag, "_reqs_quiet"}, 64'({rd_req, wr_req, strt_cpy}), 64'd0);
            exp_words = abort_k;
        end
        check_val({tag, "_stable"}, 64'(stab_err - stab_base), 64'd0);
        check_val({tag, "_nreads"}, 64'(rd_log.size() - rd_base), 64'(exp_words));
        check_val({tag, "_nwrites"}, 64'(wa_log.size() - wr_base), 64'(exp_words));
        if (rd_log.size() == rd_base + exp_words && wa_log.size() == wr_base + exp_words) begin
            for (int i = 0; i < exp_words; i++) begin
                ea = s + 32'(4 * i);
                check_val({tag, "_rd_addr"}, 64'(rd_log[rd_base + i]), 64'(ea));
                check_val({tag, "_wr_addr"}, 64'(wa_log[wr_base + i]), 64'(d + 32'(4 * i)));
                check_val({tag, "_wr_data"}, 64'(wd_log[wr_base + i]), 64'(mem_word(ea)));
            end
        end
    endtask

    initial begin
        int n;
        int k;
        nreset = 1'b0;
        go     = 1'b0;
        @(posedge aclk);
        #1;
        check_idle_outputs("reset");
        repeat (2) @(posedge aclk);
        #1;
        nreset = 1'b1;

        run_copy("nominal", 32'h0000_1000, 32'h0000_2000, 4, 0, 0, 0, 1'b0);
        run_copy("backpressure", 32'h0000_1100, 32'h0000_2100, 3, 5, 2, 0, 1'b0);
        run_copy("zero_len", 32'h0000_3000, 32'h0000_4000, 0, 0, 0, 0, 1'b0);
        run_copy("abort", 32'h0000_5000, 32'h0000_6000, 8, 1, 4, 3, 1'b0);
        run_copy("wrap", 32'hFFFF_FFF8, 32'h0000_7000, 3, 0, 0, 0, 1'b0);
        run_copy("abort_final_ack", 32'h0000_0100, 32'h0000_0200, 2, 0, 0, 2, 1'b0);

        // Reset in the middle of a copy.
        rd_delay  = 3;
        wr_delay  = 3;
        src_addr  = 32'h0000_8000;
        dst_addr  = 32'h0000_9000;
        len_words = 16'd8;
        repeat (2) @(posedge aclk);
        #1;
        go = 1'b1;
        repeat (12) @(posedge aclk);
        #1;
        nreset = 1'b0;
        go     = 1'b0;
        @(posedge aclk);
        #1;
        check_idle_outputs("midreset");
        repeat (2) @(posedge aclk);
        #1;
        check_val("midreset_held", 64'({rd_req, wr_req, strt_cpy, busy}), 64'd0);
        nreset = 1'b1;

        for (int t = 0; t < 10; t++) begin
            n = $urandom_range(0, 6);
            k = (n > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0;
            run_copy($sformatf("rand%0d", t), $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                     n, $urandom_range(0, 3), $urandom_range(0, 3), k, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
